// File: rtl/decode_pkg.sv
// decode_pkg: shared types and encodings for the decode stage.
//   ctrl_t     : packed control word from control_unit_top (CTRL_W bits).
//   TIPO_*/OP_*: instruction class / operation field encodings.
// Bit layout of ctrl_t (MSB first):
//   [12] reg_write [11] alu_src [10] mem_write [9] result_src [8] branch
//   [7:5] alu_ctrl [4:3] rgb [2] jump [1] pc_dir [0] rsvd (spare, unused)
package decode_pkg;

    localparam int CTRL_W = 13;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [2:0] alu_ctrl;
        logic [1:0] rgb;
        logic       jump;
        logic       pc_dir;
        logic       rsvd;
    } ctrl_t;

    // tipo=01/op=00 is the memory register-register form that moves the
    // destination into [22:18] and the second source into [4:0].
    localparam logic [1:0] TIPO_MEM  = 2'b01;
    localparam logic [1:0] TIPO_JMP  = 2'b10;
    localparam logic [1:0] OP_MEM_RR = 2'b00;
    localparam logic [1:0] OP_JAL    = 2'b01;

endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: NREG x DATA_W register file, 2 async read, 2 sync write.
//   clk, rst          : clock, synchronous active-high clear of all entries
//   ra1_i/ra2_i       : read addresses; rd1_o/rd2_o read data (0 if out of range)
//   we0_i/wa0_i/wd0_i : write port 0 (writeback)
//   we1_i/wa1_i/wd1_i : write port 1 (link); wins over port 0 on same address
module decode_regfile #(
    parameter  int DATA_W = 18,
    parameter  int NREG   = 32,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra1_i,
    input  logic [AW-1:0]     ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    input  logic              we0_i,
    input  logic [AW-1:0]     wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              we1_i,
    input  logic [AW-1:0]     wa1_i,
    input  logic [DATA_W-1:0] wd1_i
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (we0_i && (32'(wa0_i) < NREG)) regs_q[wa0_i] <= wd0_i;
            // Port 1 is assigned last so it wins a same-address collision.
            if (we1_i && (32'(wa1_i) < NREG)) regs_q[wa1_i] <= wd1_i;
        end
    end

    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (32'(ra1_i) < NREG) rd1_o = regs_q[ra1_i];
        if (32'(ra2_i) < NREG) rd2_o = regs_q[ra2_i];
    end

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode, register read, link write and the
// decode->execute pipeline register, with load-use hazard detection.
//   clk, rst                        : clock, synchronous active-high reset
//   instr_d_i, valid_d_i, ctrl_d_i  : decode instruction, valid, control word
//   pc_d_i, pcplus4_d_i             : PC and PC+4 of the decode instruction
//   reg_write_w_i, rd_w_i, result_w_i : writeback port
//   stall_i, flush_i                : hold / bubble the E register
//   *_e_o, valid_e_o                : E register contents
//   hazard_stall_o                  : combinational load-use stall request
// Build option: DECODE_BYPASS_EN forwards same-cycle WB/link writes into rd1/rd2.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter  int DATA_W   = 18,
    parameter  int PC_W     = 9,
    parameter  int NREG     = 32,
    parameter  int LINK_REG = 29,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [32:0]       instr_d_i,
    input  logic              valid_d_i,
    input  logic [CTRL_W-1:0] ctrl_d_i,
    input  logic [PC_W-1:0]   pc_d_i,
    input  logic [PC_W-1:0]   pcplus4_d_i,
    input  logic              reg_write_w_i,
    input  logic [AW-1:0]     rd_w_i,
    input  logic [DATA_W-1:0] result_w_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_e_o,
    output logic [DATA_W-1:0] rd1_e_o,
    output logic [DATA_W-1:0] rd2_e_o,
    output logic [DATA_W-1:0] imm_e_o,
    output logic [AW-1:0]     rs1_e_o,
    output logic [AW-1:0]     rs2_e_o,
    output logic [AW-1:0]     rd_e_o,
    output logic [PC_W-1:0]   pc_e_o,
    output logic [PC_W-1:0]   pcplus4_e_o,
    output logic              valid_e_o,
    output logic              hazard_stall_o
);

    logic        imm_bit, is_mem_rr;
    logic [1:0]  tipo, op;
    logic [AW-1:0]     a1, a2, rd_d, link_wa;
    logic [DATA_W-1:0] imm_d, rf_rd1, rf_rd2, rd1_d, rd2_d, link_wd;
    logic        link_we;

    ctrl_t             ctrl_e_q;
    logic [DATA_W-1:0] rd1_e_q, rd2_e_q, imm_e_q;
    logic [AW-1:0]     rs1_e_q, rs2_e_q, rd_e_q;
    logic [PC_W-1:0]   pc_e_q, pcplus4_e_q;
    logic              valid_e_q;

    assign imm_bit   = instr_d_i[32];
    assign tipo      = instr_d_i[31:30];
    assign op        = instr_d_i[29:28];
    assign is_mem_rr = (tipo == TIPO_MEM) && (op == OP_MEM_RR);

    assign a1    = AW'(instr_d_i[27:23]);
    assign a2    = (!imm_bit && is_mem_rr) ? AW'(instr_d_i[4:0]) : AW'(instr_d_i[22:18]);
    assign rd_d  = (is_mem_rr || imm_bit) ? AW'(instr_d_i[22:18]) : AW'(instr_d_i[4:0]);
    // Size cast of a signed value sign-extends when widening, truncates when narrowing.
    assign imm_d = DATA_W'($signed(instr_d_i[17:0]));

    assign hazard_stall_o = valid_e_q & ctrl_e_q.reg_write & ctrl_e_q.result_src & valid_d_i
                          & ((rd_e_q == a1) | (rd_e_q == a2));

    // Link is only written when the jump actually advances into E.
    assign link_we = valid_d_i && (tipo == TIPO_JMP) && (op == OP_JAL)
                   && !hazard_stall_o && !stall_i && !flush_i;
    assign link_wa = AW'(LINK_REG);
    assign link_wd = DATA_W'(pc_d_i);

    decode_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (a1),
        .ra2_i (a2),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we0_i (reg_write_w_i),
        .wa0_i (rd_w_i),
        .wd0_i (result_w_i),
        .we1_i (link_we),
        .wa1_i (link_wa),
        .wd1_i (link_wd)
    );

`ifdef DECODE_BYPASS_EN
    always_comb begin
        rd1_d = rf_rd1;
        rd2_d = rf_rd2;
        if (32'(a1) < NREG) begin
            if (link_we && (a1 == link_wa))             rd1_d = link_wd;
            else if (reg_write_w_i && (rd_w_i == a1))  rd1_d = result_w_i;
        end
        if (32'(a2) < NREG) begin
            if (link_we && (a2 == link_wa))             rd2_d = link_wd;
            else if (reg_write_w_i && (rd_w_i == a2))  rd2_d = result_w_i;
        end
    end
`else
    assign rd1_d = rf_rd1;
    assign rd2_d = rf_rd2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_e_q    <= '0;
            rd1_e_q     <= '0;
            rd2_e_q     <= '0;
            imm_e_q     <= '0;
            rs1_e_q     <= '0;
            rs2_e_q     <= '0;
            rd_e_q      <= '0;
            pc_e_q      <= '0;
            pcplus4_e_q <= '0;
            valid_e_q   <= 1'b0;
        end else if (flush_i) begin
            valid_e_q <= 1'b0;
            ctrl_e_q  <= '0;
        end else if (stall_i) begin
            valid_e_q <= valid_e_q;
        end else if (hazard_stall_o) begin
            valid_e_q <= 1'b0;
            ctrl_e_q  <= '0;
        end else begin
            valid_e_q   <= valid_d_i;
            ctrl_e_q    <= valid_d_i ? ctrl_t'(ctrl_d_i) : '0;
            rd1_e_q     <= rd1_d;
            rd2_e_q     <= rd2_d;
            imm_e_q     <= imm_d;
            rs1_e_q     <= a1;
            rs2_e_q     <= a2;
            rd_e_q      <= rd_d;
            pc_e_q      <= pc_d_i;
            pcplus4_e_q <= pcplus4_d_i;
        end
    end

    assign ctrl_e_o    = ctrl_e_q;
    assign rd1_e_o     = rd1_e_q;
    assign rd2_e_o     = rd2_e_q;
    assign imm_e_o     = imm_e_q;
    assign rs1_e_o     = rs1_e_q;
    assign rs2_e_o     = rs2_e_q;
    assign rd_e_o      = rd_e_q;
    assign pc_e_o      = pc_e_q;
    assign pcplus4_e_o = pcplus4_e_q;
    assign valid_e_o   = valid_e_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: behavioural model + per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
module tb_decode_stage_p;

    localparam int DATA_W = 18;
    localparam int PC_W   = 9;
    localparam int NREG   = 32;
    localparam int LINK   = 29;
    localparam int AW     = 5;
    localparam int CW     = 13;

    localparam logic [CW-1:0] C_ALU  = 13'h1040; // reg_write, alu_ctrl=010
    localparam logic [CW-1:0] C_LOAD = 13'h1200; // reg_write, result_src
    localparam logic [CW-1:0] C_JAL  = 13'h1004; // reg_write, jump

    logic              clk = 1'b0;
    logic              rst;
    logic [32:0]       instr_d_i;
    logic              valid_d_i;
    logic [CW-1:0]     ctrl_d_i;
    logic [PC_W-1:0]   pc_d_i, pcplus4_d_i;
    logic              reg_write_w_i;
    logic [AW-1:0]     rd_w_i;
    logic [DATA_W-1:0] result_w_i;
    logic              stall_i, flush_i;
    logic [CW-1:0]     ctrl_e_o;
    logic [DATA_W-1:0] rd1_e_o, rd2_e_o, imm_e_o;
    logic [AW-1:0]     rs1_e_o, rs2_e_o, rd_e_o;
    logic [PC_W-1:0]   pc_e_o, pcplus4_e_o;
    logic              valid_e_o, hazard_stall_o;

    int n_assert = 0;
    int n_fail   = 0;

    decode_stage_p dut (
        .clk(clk), .rst(rst), .instr_d_i(instr_d_i), .valid_d_i(valid_d_i),
        .ctrl_d_i(ctrl_d_i), .pc_d_i(pc_d_i), .pcplus4_d_i(pcplus4_d_i),
        .reg_write_w_i(reg_write_w_i), .rd_w_i(rd_w_i), .result_w_i(result_w_i),
        .stall_i(stall_i), .flush_i(flush_i), .ctrl_e_o(ctrl_e_o),
        .rd1_e_o(rd1_e_o), .rd2_e_o(rd2_e_o), .imm_e_o(imm_e_o),
        .rs1_e_o(rs1_e_o), .rs2_e_o(rs2_e_o), .rd_e_o(rd_e_o),
        .pc_e_o(pc_e_o), .pcplus4_e_o(pcplus4_e_o), .valid_e_o(valid_e_o),
        .hazard_stall_o(hazard_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] mreg [NREG];
    logic              m_valid;
    logic [CW-1:0]     m_ctrl;
    logic [DATA_W-1:0] m_rd1, m_rd2, m_imm;
    logic [AW-1:0]     m_rs1, m_rs2, m_rd;
    logic [PC_W-1:0]   m_pc, m_pc4;
    bit                m_known = 1'b0;
    bit                m_init  = 1'b0;

    function automatic logic [4:0] f_a1(input logic [32:0] ins);
        return ins[27:23];
    endfunction
    function automatic logic [4:0] f_a2(input logic [32:0] ins);
        return (!ins[32] && ins[31:30] == 2'b01 && ins[29:28] == 2'b00) ? ins[4:0] : ins[22:18];
    endfunction
    function automatic logic [4:0] f_rd(input logic [32:0] ins);
        return ((ins[31:30] == 2'b01 && ins[29:28] == 2'b00) || ins[32]) ? ins[22:18] : ins[4:0];
    endfunction
    function automatic bit exp_hazard();
        // E holds a valid load (reg_write and result_src set) and decode reads its rd.
        return m_valid && m_ctrl[12] && m_ctrl[9] && valid_d_i &&
               (m_rd == f_a1(instr_d_i) || m_rd == f_a2(instr_d_i));
    endfunction

    always @(posedge clk) begin : model
        logic [4:0]        a1, a2;
        logic [DATA_W-1:0] v1, v2, lv;
        bit                hz, lnk;
        if (rst) begin
            for (int i = 0; i < NREG; i++) mreg[i] = '0;
            m_valid = 0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_pc = '0; m_pc4 = '0;
            m_known = 1'b1;
            m_init  = 1'b1;
        end else if (m_init) begin
            a1  = f_a1(instr_d_i);
            a2  = f_a2(instr_d_i);
            hz  = exp_hazard();
            lnk = valid_d_i && instr_d_i[31:30] == 2'b10 && instr_d_i[29:28] == 2'b01
                  && !hz && !stall_i && !flush_i;
            lv  = {{(DATA_W-PC_W){1'b0}}, pc_d_i};
            v1  = mreg[a1];
            v2  = mreg[a2];
`ifdef DECODE_BYPASS_EN
            if (reg_write_w_i && rd_w_i == a1) v1 = result_w_i;
            if (reg_write_w_i && rd_w_i == a2) v2 = result_w_i;
            if (lnk && a1 == LINK) v1 = lv;
            if (lnk && a2 == LINK) v2 = lv;
`endif
            if (flush_i || (!stall_i && hz)) begin
                m_valid = 0; m_ctrl = '0; m_known = 1'b0;
            end else if (!stall_i) begin
                m_valid = valid_d_i;
                m_ctrl  = valid_d_i ? ctrl_d_i : '0;
                m_rd1 = v1; m_rd2 = v2; m_imm = instr_d_i[17:0];
                m_rs1 = a1; m_rs2 = a2; m_rd = f_rd(instr_d_i);
                m_pc = pc_d_i; m_pc4 = pcplus4_d_i;
                m_known = 1'b1;
            end
            if (reg_write_w_i) mreg[rd_w_i] = result_w_i;
            if (lnk) mreg[LINK] = lv;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_init) begin
            chk("valid_e", valid_e_o, m_valid);
            chk("ctrl_e", ctrl_e_o, m_ctrl);
            chk("hazard", hazard_stall_o, exp_hazard());
            if (m_known) begin
                chk("rd1_e", rd1_e_o, m_rd1);
                chk("rd2_e", rd2_e_o, m_rd2);
                chk("imm_e", imm_e_o, m_imm);
                chk("rs1_e", rs1_e_o, m_rs1);
                chk("rs2_e", rs2_e_o, m_rs2);
                chk("rd_e", rd_e_o, m_rd);
                chk("pc_e", pc_e_o, m_pc);
                chk("pc4_e", pcplus4_e_o, m_pc4);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [32:0] mk(input logic i, input logic [1:0] t, input logic [1:0] o,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [17:0] im);
        return {i, t, o, r1, r2, im};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic v, input logic [32:0] ins, input logic [CW-1:0] c,
                       input logic [PC_W-1:0] pc);
        valid_d_i = v; instr_d_i = ins; ctrl_d_i = c; pc_d_i = pc; pcplus4_d_i = pc + 9'd4;
    endtask

    task automatic wb(input logic we, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        reg_write_w_i = we; rd_w_i = a; result_w_i = d;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; stall_i = 0; flush_i = 0;
        dec(0, '0, '0, '0);
        wb(0, '0, '0);
        tick(); tick();
        chk("rst_valid", valid_e_o, 0);
        chk("rst_ctrl", ctrl_e_o, 0);
        chk("rst_rd1", rd1_e_o, 0);
        chk("rst_pc", pc_e_o, 0);
        chk("rst_hazard", hazard_stall_o, 0);
        rst = 1'b0;

        // Write R5 via WB, read it the following cycle.
        wb(1, 5'd5, 18'h00123);
        tick();
        wb(0, '0, '0);
        dec(1, mk(0, 2'b00, 2'b00, 5'd5, 5'd6, 18'h00003), C_ALU, 9'h010);
        tick();
        chk("wb_then_read_rd1", rd1_e_o, 18'h00123);
        chk("wb_then_read_valid", valid_e_o, 1);
        chk("wb_then_read_rd", rd_e_o, 5'd3);

        // Same-cycle WB and read.
        wb(1, 5'd5, 18'h00003);
        dec(1, mk(0, 2'b00, 2'b00, 5'd5, 5'd6, 18'h00003), C_ALU, 9'h014);
        tick();
        wb(0, '0, '0);
`ifdef DECODE_BYPASS_EN
        chk("same_cycle_rd1", rd1_e_o, 18'h00003);
`else
        chk("same_cycle_rd1", rd1_e_o, 18'h00123);
`endif

        // Load-use hazard.
        dec(1, mk(1, 2'b01, 2'b00, 5'd2, 5'd7, 18'h00010), C_LOAD, 9'h018);
        tick();
        chk("load_rd_e", rd_e_o, 5'd7);
        chk("load_ctrl_e", ctrl_e_o, C_LOAD);
        dec(1, mk(0, 2'b00, 2'b00, 5'd1, 5'd7, 18'h00000), C_ALU, 9'h01C);
        #1;
        chk("hazard_raised", hazard_stall_o, 1);
        tick();
        chk("hazard_bubble_valid", valid_e_o, 0);
        chk("hazard_bubble_ctrl", ctrl_e_o, 0);
        tick();
        chk("after_hazard_valid", valid_e_o, 1);
        chk("after_hazard_rs2", rs2_e_o, 5'd7);
        chk("after_hazard_ctrl", ctrl_e_o, C_ALU);

        // Jump-and-link with simultaneous WB to the link register.
        dec(1, mk(0, 2'b10, 2'b01, 5'd0, 5'd0, 18'h00000), C_JAL, 9'h1A4);
        wb(1, 5'd29, 18'h00055);
        tick();
        wb(0, '0, '0);
        dec(1, mk(0, 2'b00, 2'b00, 5'd29, 5'd29, 18'h00000), C_ALU, 9'h1A8);
        tick();
        chk("link_rd1", rd1_e_o, 18'h001A4);
        chk("link_rd2", rd2_e_o, 18'h001A4);

        // stall+flush together bubbles; stall alone holds.
        stall_i = 1; flush_i = 1;
        tick();
        chk("stall_flush_valid", valid_e_o, 0);
        chk("stall_flush_ctrl", ctrl_e_o, 0);
        stall_i = 0; flush_i = 0;
        dec(1, mk(0, 2'b00, 2'b00, 5'd5, 5'd29, 18'h3FFF0), C_ALU, 9'h0C0);
        tick();
        chk("pre_stall_imm", imm_e_o, 18'h3FFF0);
        stall_i = 1;
        for (int k = 0; k < 3; k++) begin
            dec(1, mk(0, 2'b00, 2'b00, 5'(k + 1), 5'd2, 18'(k)), C_LOAD, 9'(9'h111 + k));
            tick();
            chk("stall_pc", pc_e_o, 9'h0C0);
            chk("stall_rd1", rd1_e_o, 18'h00003);
            chk("stall_rd2", rd2_e_o, 18'h001A4);
            chk("stall_valid", valid_e_o, 1);
        end
        stall_i = 0;

        // Reset during a hazard stall.
        dec(1, mk(1, 2'b01, 2'b00, 5'd2, 5'd7, 18'h00000), C_LOAD, 9'h030);
        tick();
        dec(1, mk(0, 2'b00, 2'b00, 5'd7, 5'd1, 18'h00000), C_ALU, 9'h034);
        #1;
        chk("hazard_before_rst", hazard_stall_o, 1);
        rst = 1;
        tick();
        chk("rst_mid_valid", valid_e_o, 0);
        chk("rst_mid_ctrl", ctrl_e_o, 0);
        chk("rst_mid_rd", rd_e_o, 0);
        chk("rst_mid_hazard", hazard_stall_o, 0);
        rst = 0;
        dec(1, mk(0, 2'b00, 2'b00, 5'd5, 5'd29, 18'h00000), C_ALU, 9'h020);
        tick();
        chk("rf_cleared_rd1", rd1_e_o, 0);
        chk("rf_cleared_rd2", rd2_e_o, 0);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            stall_i = ($urandom_range(0, 7) == 0);
            flush_i = ($urandom_range(0, 15) == 0);
            r = $urandom();
            dec($urandom_range(0, 3) != 0,
                mk(r[0], r[2:1], r[4:3], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   {r[31:19], 5'($urandom_range(0, 7))}),
                13'($urandom()), 9'($urandom()));
            if ($urandom_range(0, 3) == 0) ctrl_d_i[12] = 1'b1;
            if ($urandom_range(0, 3) == 0) ctrl_d_i[9] = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                instr_d_i[31:28] = 4'b1001;
                instr_d_i[27:23] = 5'($urandom_range(27, 31));
            end
            wb($urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? 5'd29 : 5'($urandom_range(0, 7)),
               18'($urandom()));
            tick();
        end
        rst = 0; stall_i = 0; flush_i = 0;
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
